// File: rtl/srio2udp_interface.sv
// SRIO-to-UDP width converter: each 64-bit SRIO beat becomes up to two 32-bit UDP words, upper half first.
// Optional statistics counters are built only when SRIO2UDP_STATS_EN is defined.
`timescale 1ns/1ps
module srio2udp_interface #(
   parameter int DATA_WIDTH   = 64,
   parameter int LENGTH_WIDTH = 16
) (
   input  logic                      clk_srio,
   input  logic                      reset_srio,
   input  logic [DATA_WIDTH-1:0]     srio_data_in,
   input  logic [DATA_WIDTH/8-1:0]   srio_keep_in,
   input  logic                      srio_valid_in,
   input  logic                      srio_first_in,
   input  logic                      srio_last_in,
   input  logic [LENGTH_WIDTH-1:0]   srio_length_in,
   output logic                      srio_ready_out,
   output logic [DATA_WIDTH/2-1:0]   udp_data_out,
   output logic [DATA_WIDTH/16-1:0]  udp_keep_out,
   output logic                      udp_valid_out,
   output logic                      udp_first_out,
   output logic                      udp_last_out,
   output logic [LENGTH_WIDTH-1:0]   udp_length_out,
   input  logic                      udp_ready_in,
   output logic [31:0]               frame_cnt_out,
   output logic [15:0]               drop_cnt_out
);
   localparam int HW = DATA_WIDTH / 2;
   localparam int KW = DATA_WIDTH / 8;
   localparam int KH = KW / 2;

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_HI    = 2'd1;
   localparam logic [1:0] S_LO    = 2'd2;

   logic [1:0]              state;
   logic [DATA_WIDTH-1:0]   h_data;
   logic [KW-1:0]           h_keep;
   logic                    h_first;
   logic                    h_last;
   logic [LENGTH_WIDTH-1:0] length_q;

   logic hi_nz, lo_nz, in_hi_nz, in_lo_nz;
   logic final_word, beat_done, accept;

   assign hi_nz    = |h_keep[KW-1:KH];
   assign lo_nz    = |h_keep[KH-1:0];
   assign in_hi_nz = |srio_keep_in[KW-1:KH];
   assign in_lo_nz = |srio_keep_in[KH-1:0];

   // The final word of H is the lower word, or the upper word when the lower half is empty.
   assign final_word     = (state == S_LO) || ((state == S_HI) && !lo_nz);
   assign beat_done      = udp_ready_in && final_word;
   assign srio_ready_out = !reset_srio && ((state == S_EMPTY) || beat_done);
   assign accept         = srio_valid_in && srio_ready_out;

   always_ff @(posedge clk_srio) begin
      if (reset_srio) begin
         state    <= S_EMPTY;
         h_data   <= '0;
         h_keep   <= '0;
         h_first  <= 1'b0;
         h_last   <= 1'b0;
         length_q <= '0;
      end else if ((state == S_HI) && udp_ready_in && lo_nz) begin
         state <= S_LO;
      end else if (accept) begin
         // Keep-zero beats are discarded without touching H or the length.
         if (in_hi_nz)      state <= S_HI;
         else if (in_lo_nz) state <= S_LO;
         else               state <= S_EMPTY;
         if (in_hi_nz || in_lo_nz) begin
            h_data  <= srio_data_in;
            h_keep  <= srio_keep_in;
            h_first <= srio_first_in;
            h_last  <= srio_last_in;
            if (srio_first_in) length_q <= srio_length_in;
         end
      end else if (beat_done) begin
         state <= S_EMPTY;
      end
   end

   always_comb begin
      udp_data_out  = '0;
      udp_keep_out  = '0;
      udp_first_out = 1'b0;
      udp_last_out  = 1'b0;
      case (state)
         S_HI: begin
            udp_data_out  = h_data[DATA_WIDTH-1:HW];
            udp_keep_out  = h_keep[KW-1:KH];
            udp_first_out = h_first;
            udp_last_out  = h_last && !lo_nz;
         end
         S_LO: begin
            udp_data_out  = h_data[HW-1:0];
            udp_keep_out  = h_keep[KH-1:0];
            udp_first_out = h_first && !hi_nz;
            udp_last_out  = h_last;
         end
         default: ;
      endcase
   end

   assign udp_valid_out  = (state != S_EMPTY);
   assign udp_length_out = length_q;

`ifdef SRIO2UDP_STATS_EN
   logic [31:0] frame_cnt_q;
   logic [15:0] drop_cnt_q;

   always_ff @(posedge clk_srio) begin
      if (reset_srio) begin
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (udp_valid_out && udp_ready_in && udp_last_out) frame_cnt_q <= frame_cnt_q + 32'd1;
         if (accept && !(in_hi_nz || in_lo_nz))             drop_cnt_q  <= drop_cnt_q + 16'd1;
      end
   end

   assign frame_cnt_out = frame_cnt_q;
   assign drop_cnt_out  = drop_cnt_q;
`else
   assign frame_cnt_out = '0;
   assign drop_cnt_out  = '0;
`endif
endmodule
